extracted_reg_chain_pipe: RTL and testbench
===========================================

// Module: extracted_reg_chain_pipe
// PURPOSE
//  Parametrised successor of the two-register extracted-unit chain: a STAGES-deep
//  register pipeline of DATA_WIDTH bits, one extracted stage per register, with a
//  valid/ready handshake, back-pressure and flush. Stage 0 computes i+ADD_CONST;
//  every later stage computes (prev^XOR_MASK)+ADD_CONST+prev. Sits between a
//  streaming producer and consumer in hierarchy/extraction examples.
// PARAMETERS
//  DATA_WIDTH  8   width of data path and every stage register
//  STAGES      2   number of register stages, >=1
//  XOR_MASK    1   DATA_WIDTH-bit mask applied in stages 1..STAGES-1
//  ADD_CONST   1   DATA_WIDTH-bit constant added in every stage
// PORTS
//  clk       in   1           single clock, all state on rising edge
//  rst_n     in   1           synchronous reset, active-low
//  flush     in   1           synchronous pipeline clear
//  i_data    in   DATA_WIDTH  input word
//  i_valid   in   1           input word valid
//  i_ready   out  1           pipeline accepts i_data this cycle
//  o_data    out  DATA_WIDTH  result of last stage
//  o_valid   out  1           o_data valid
//  o_ready   in   1           consumer accepts o_data this cycle
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): all stage valids 0, all stage data 0x0;
//    o_valid=0, o_data=0. Reset dominates flush and all handshakes.
//  - Per stage k: valid v[k], data d[k]. adv[STAGES-1] = o_ready | ~v[STAGES-1];
//    adv[k] = ~v[k] | adv[k+1]. Stage k loads when adv[k]: v[k]<=v[k-1]
//    (v[-1]=i_valid), d[k]<=f_k(src); when ~adv[k] stage holds.
//  - d[k] loads only if upstream valid; bubbles keep the old d[k] (don't-care).
//  - i_ready = adv[0] & ~flush (combinational ready chain, no skid buffer).
//  - Transfer on i_valid&i_ready and on o_valid&o_ready, same-cycle both legal.
//  - Latency STAGES cycles i-accept -> o_valid with o_ready held 1; throughput
//    1 word/cycle; order preserved, no drop, no duplication.
//  - Stall: o_valid=1 & o_ready=0 holds o_data stable; bubbles upstream still
//    collapse (stage with v=0 loads even while downstream stalls).
//  - Arithmetic: all sums modulo 2^DATA_WIDTH, carries discarded, unsigned.
//  - flush=1 at edge: all v<=0 next cycle; i_ready=0 that cycle so no input
//    is accepted; an output handshake in the flush cycle still completes.
//  - o_data/o_valid are registered outputs (last stage regs); no comb path
//    i_data->o_data. Ready path o_ready->i_ready is combinational by design.
//  - STAGES=1: only the stage-0 function applies.
// STRUCTURE
//  - Package extracted_reg_chain_pkg: stage_func_first(x)=x+ADD_CONST,
//    stage_func_next(x)=(x^XOR_MASK)+ADD_CONST+x as width-generic functions;
//    default DATA_WIDTH/XOR_MASK/ADD_CONST constants.
//  - Sub-module extracted_reg_stage (params DATA_WIDTH, FIRST, XOR_MASK,
//    ADD_CONST; ports clk, rst_n, flush, in_valid, in_data, adv, valid, data):
//    one register + valid bit + its function. Top generates STAGES instances
//    and the adv chain.
// TESTING
//  1. W=8,S=2: rst_n=0 3 cycles -> o_valid=0,o_data=0x00,i_ready=1 after release.
//  2. i_data=0x05 one beat, o_ready=1 -> o_valid at cycle+2, o_data=0x0E.
//  3. Wrap: i_data=0xFF -> stage0 0x00, o_data=0x02; S=3 with 0x05 -> 0x1E.
//  4. Back-pressure: stream 0x00..0x0F, o_ready random 50% -> output sequence
//     equals model, o_data stable while o_valid&~o_ready, i_ready=0 when full.
//  5. flush with 2 words in flight, o_ready=0 -> next cycle o_valid=0, flushed
//     words never appear; next input 0x05 yields 0x0E after 2 cycles.
//  6. rst_n=0 mid-stream with o_ready=0 -> all valids 0 next cycle, data 0x00,
//     no stale word emitted after release.

Source files
------------

// File: rtl/extracted_reg_chain_pipe_pkg.sv
// Shared stage functions and default constants for the extracted register chain pipeline.
// Functions work on a wide word and the caller truncates, so they serve any DATA_WIDTH <= FUNC_W.
package extracted_reg_chain_pkg;

  localparam int unsigned FUNC_W         = 64;
  localparam int unsigned DEF_DATA_WIDTH = 8;

  typedef logic [FUNC_W-1:0] func_word_t;

  localparam func_word_t DEF_XOR_MASK  = 64'd1;
  localparam func_word_t DEF_ADD_CONST = 64'd1;

  function automatic func_word_t stage_func_first(input func_word_t x,
                                                  input func_word_t add_const);
    return x + add_const;
  endfunction

  function automatic func_word_t stage_func_next(input func_word_t x,
                                                 input func_word_t xor_mask,
                                                 input func_word_t add_const);
    return (x ^ xor_mask) + add_const + x;
  endfunction

endpackage

// File: rtl/extracted_reg_chain_pipe_stage.sv
// One pipeline stage: data register, valid bit and the stage transfer function.
module extracted_reg_stage
  import extracted_reg_chain_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
  parameter bit                    FIRST      = 1'b1,
  parameter logic [DATA_WIDTH-1:0] XOR_MASK   = DATA_WIDTH'(DEF_XOR_MASK),
  parameter logic [DATA_WIDTH-1:0] ADD_CONST  = DATA_WIDTH'(DEF_ADD_CONST)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  adv,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data
);

  logic [DATA_WIDTH-1:0] next_data;

  // Truncation back to DATA_WIDTH gives the modulo-2^DATA_WIDTH result.
  always_comb begin
    next_data = '0;
    if (FIRST)
      next_data = DATA_WIDTH'(stage_func_first(FUNC_W'(in_data), FUNC_W'(ADD_CONST)));
    else
      next_data = DATA_WIDTH'(stage_func_next(FUNC_W'(in_data), FUNC_W'(XOR_MASK),
                                              FUNC_W'(ADD_CONST)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else begin
      if (flush)
        valid <= 1'b0;
      else if (adv)
        valid <= in_valid;
      // Bubbles leave the old word in place; its value is don't-care.
      if (adv && in_valid && !flush)
        data <= next_data;
    end
  end

endmodule

// File: rtl/extracted_reg_chain_pipe.sv
// STAGES-deep valid/ready register pipeline built from extracted_reg_stage instances,
// with bubble-collapsing back-pressure and a synchronous flush.
module extracted_reg_chain_pipe
  import extracted_reg_chain_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned           STAGES     = 2,
  parameter logic [DATA_WIDTH-1:0] XOR_MASK   = DATA_WIDTH'(DEF_XOR_MASK),
  parameter logic [DATA_WIDTH-1:0] ADD_CONST  = DATA_WIDTH'(DEF_ADD_CONST)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  o_ready
);

  logic [STAGES-1:0]     v;
  logic [STAGES-1:0]     adv;
  logic [DATA_WIDTH-1:0] d [STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Recursive adv chain unrolled: stage k may move unless it and every stage below is full and stalled.
    assign adv[k] = o_ready | ~(&v[STAGES-1:k]);

    if (k == 0) begin : g_first
      extracted_reg_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIRST      (1'b1),
        .XOR_MASK   (XOR_MASK),
        .ADD_CONST  (ADD_CONST)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (i_valid),
        .in_data  (i_data),
        .adv      (adv[k]),
        .valid    (v[k]),
        .data     (d[k])
      );
    end else begin : g_next
      extracted_reg_stage #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIRST      (1'b0),
        .XOR_MASK   (XOR_MASK),
        .ADD_CONST  (ADD_CONST)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (v[k-1]),
        .in_data  (d[k-1]),
        .adv      (adv[k]),
        .valid    (v[k]),
        .data     (d[k])
      );
    end
  end

  assign i_ready = adv[0] & ~flush;
  assign o_valid = v[STAGES-1];
  assign o_data  = d[STAGES-1];

endmodule

// File: tb/tb_extracted_reg_chain_pipe.sv
// Self-checking bench for extracted_reg_chain_pipe: vector table, directed corner cases,
// and randomized back-pressure checked against an in-order scoreboard.
module tb_extracted_reg_chain_pipe;

  logic       clk = 1'b0;
  logic       rst_n, flush;
  logic [7:0] i_data, o_data;
  logic       i_valid, i_ready, o_valid, o_ready;

  logic [7:0] i_data3, o_data3;
  logic       i_valid3, i_ready3, o_valid3, o_ready3;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  extracted_reg_chain_pipe #(.DATA_WIDTH(8), .STAGES(2), .XOR_MASK(8'h01), .ADD_CONST(8'h01)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .i_data(i_data), .i_valid(i_valid), .i_ready(i_ready),
    .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready)
  );

  extracted_reg_chain_pipe #(.DATA_WIDTH(8), .STAGES(3), .XOR_MASK(8'h01), .ADD_CONST(8'h01)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .i_data(i_data3), .i_valid(i_valid3), .i_ready(i_ready3),
    .o_data(o_data3), .o_valid(o_valid3), .o_ready(o_ready3)
  );

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: apply the stage rules word-by-word with integer arithmetic mod 256.
  function automatic logic [7:0] ref_out(input logic [7:0] x, input int unsigned stages);
    int unsigned y;
    y = (int'(x) + 1) % 256;
    for (int unsigned k = 1; k < stages; k++)
      y = ((y ^ 1) + 1 + y) % 256;
    return y[7:0];
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  q [$];
    logic [7:0]  held, exp_d;
    logic        stalled, in_x, out_x, exp_ready;
    int unsigned sent, got, inflight, seen;

    vecs[0] = '{8'h05, 8'h0E};
    vecs[1] = '{8'hFF, 8'h02};
    vecs[2] = '{8'h00, 8'h02};
    vecs[3] = '{8'h10, 8'h22};
    vecs[4] = '{8'hAA, 8'h56};
    vecs[5] = '{8'h03, 8'h0A};
    vecs[6] = '{8'h7E, 8'hFE};
    vecs[7] = '{8'h40, 8'h82};

    rst_n = 1'b0; flush = 1'b0;
    i_data = '0; i_valid = 1'b0; o_ready = 1'b0;
    i_data3 = '0; i_valid3 = 1'b0; o_ready3 = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_o_valid", o_valid, 0);
    check("rst_o_data", o_data, 0);
    check("rst_o_valid3", o_valid3, 0);
    rst_n = 1'b1;
    #1;
    check("rst_i_ready", i_ready, 1);
    tick();

    // Single-beat latency table, S=2
    for (int i = 0; i < 8; i++) begin
      o_ready = 1'b1; i_data = vecs[i].din; i_valid = 1'b1;
      #1;
      check("tab_i_ready", i_ready, 1);
      tick();
      i_valid = 1'b0;
      check("tab_early_valid", o_valid, 0);
      tick();
      check("tab_valid", o_valid, 1);
      check("tab_data", o_data, vecs[i].exp);
      check("tab_model", vecs[i].exp, ref_out(vecs[i].din, 2));
      tick();
      check("tab_drained", o_valid, 0);
    end

    // S=3 latency and arithmetic
    for (int i = 0; i < 2; i++) begin
      exp_d = (i == 0) ? 8'h1E : 8'h06;
      o_ready3 = 1'b1; i_data3 = (i == 0) ? 8'h05 : 8'hFF; i_valid3 = 1'b1;
      tick();
      i_valid3 = 1'b0;
      tick();
      check("s3_early_valid", o_valid3, 0);
      tick();
      check("s3_valid", o_valid3, 1);
      check("s3_data", o_data3, exp_d);
      tick();
    end

    // Random back-pressure stream 0x00..0x0F against the in-order scoreboard
    sent = 0; got = 0; inflight = 0; stalled = 1'b0; held = '0;
    for (int cyc = 0; cyc < 600 && got < 16; cyc++) begin
      o_ready = 1'($urandom_range(0, 1));
      i_valid = (sent < 16) ? ($urandom_range(0, 3) != 0) : 1'b0;
      i_data  = sent[7:0];
      #1;
      exp_ready = o_ready | (inflight < 2);
      check("bp_i_ready", i_ready, exp_ready);
      if (inflight == 0) check("bp_empty_valid", o_valid, 0);
      if (stalled) begin
        check("bp_stall_valid", o_valid, 1);
        check("bp_stall_data", o_data, held);
      end
      out_x = o_valid & o_ready;
      in_x  = i_valid & i_ready;
      if (out_x) begin
        if (q.size() == 0) check("bp_unexpected_out", 1, 0);
        else check("bp_out_data", o_data, q.pop_front());
        got++;
        if (inflight > 0) inflight--;
      end
      if (in_x) begin
        q.push_back(ref_out(i_data, 2));
        sent++;
        inflight++;
      end
      stalled = o_valid & ~o_ready;
      held = o_data;
      tick();
    end
    check("bp_all_sent", sent, 16);
    check("bp_all_got", got, 16);
    o_ready = 1'b0; i_valid = 1'b0;
    tick();

    // Flush with two words in flight while the consumer stalls
    i_valid = 1'b1; i_data = 8'h11; tick();
    i_data = 8'h22; tick();
    i_valid = 1'b0;
    check("fl_full_valid", o_valid, 1);
    i_valid = 1'b1; i_data = 8'h33; flush = 1'b1;
    #1;
    check("fl_i_ready", i_ready, 0);
    tick();
    flush = 1'b0; i_valid = 1'b0;
    check("fl_cleared", o_valid, 0);
    o_ready = 1'b1; i_data = 8'h05; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    check("fl_early_valid", o_valid, 0);
    tick();
    check("fl_valid", o_valid, 1);
    check("fl_data", o_data, 8'h0E);
    tick();
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (o_valid) seen++;
      tick();
    end
    check("fl_no_stale", seen, 0);

    // Reset in mid-stream with the consumer stalled
    o_ready = 1'b0; i_valid = 1'b1; i_data = 8'h44; tick();
    i_data = 8'h55; tick();
    i_valid = 1'b0;
    check("mr_full_valid", o_valid, 1);
    rst_n = 1'b0;
    tick();
    check("mr_valid", o_valid, 0);
    check("mr_data", o_data, 0);
    rst_n = 1'b1; o_ready = 1'b1;
    #1;
    check("mr_i_ready", i_ready, 1);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (o_valid) seen++;
    end
    check("mr_no_stale", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
